// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared types and helpers for the scan decoder.
// Mode enum, one-hot helper, dwell counter width helper.
package scan_decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int MAX_SEL_W = 6;
  localparam int MAX_N     = 1 << MAX_SEL_W;

  // clog2 with a floor of one bit so DWELL=1 still has a register
  function automatic int cnt_w(input int dwell);
    return (dwell <= 2) ? 1 : $clog2(dwell);
  endfunction

  // widest one-hot; callers truncate to their own N
  function automatic logic [MAX_N-1:0] onehot(
    input logic [MAX_SEL_W-1:0] s
  );
    return {{(MAX_N-1){1'b0}}, 1'b1} << s;
  endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// scan_decoder_if: control inputs (en, mode, sel) and decoded outputs
// (y, idx, wrap); master drives controls, slave drives outputs.
interface scan_decoder_if #(
  parameter int SEL_W = 2
);
  localparam int N = 1 << SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     y;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (
    output en, mode, sel,
    input  y, idx, wrap
  );

  modport slave (
    input  en, mode, sel,
    output y, idx, wrap
  );
endinterface

// File: rtl/scan_decoder_timer.sv
// dwell_timer: counts run cycles 0..DWELL-1; tick marks the last one.
// Ports: clk, rst (async high), clr, run in; tick out.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);
  import scan_decoder_pkg::*;

  localparam int CW = cnt_w(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with direct and auto-scan modes.
// Ports: clk, rst (async high), bus (slave: en/mode/sel in, y/idx/wrap out).
module scan_decoder #(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input logic           clk,
  input logic           rst,
  scan_decoder_if.slave bus
);
  import scan_decoder_pkg::*;

  localparam int N = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

  mode_e            mode_q;
  mode_e            mode_n;
  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_n;
  logic [N-1:0]     y_q;
  logic [N-1:0]     y_n;
  logic             wrap_q;
  logic             wrap_n;
  logic             in_scan;
  logic             clr;
  logic             run;
  logic             tick;

  // scanning only once mode has been high for an edge already;
  // direct mode and the entry edge both load idx from sel
  assign mode_n  = bus.mode ? MODE_SCAN : MODE_DIRECT;
  assign in_scan = bus.mode && (mode_q == MODE_SCAN);
  assign clr     = !in_scan;
  assign run     = in_scan && bus.en;

  dwell_timer #(
    .DWELL(DWELL)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .run  (run),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_DIRECT;
      idx_q  <= '0;
      y_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_n;
      idx_q  <= idx_n;
      y_q    <= y_n;
      wrap_q <= wrap_n;
    end
  end

  always_comb begin
    idx_n  = idx_q;
    y_n    = '0;
    wrap_n = 1'b0;
    unique case (1'b1)
      clr: begin
        idx_n = bus.sel;
        if (bus.en) begin
          y_n = N'(onehot(MAX_SEL_W'(bus.sel)));
        end
      end
      run: begin
        if (tick) begin
          idx_n  = idx_q + SEL_W'(1);
          wrap_n = (idx_q == LAST);
        end
        y_n = N'(onehot(MAX_SEL_W'(idx_n)));
      end
      default: begin
      end
    endcase
  end

  assign bus.y    = y_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: vector table, directed corner sequences and random
// stimulus against a dwell-arithmetic model, on two parameter sets.
module tb_scan_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  scan_decoder_if #(.SEL_W(2)) ba ();
  scan_decoder_if #(.SEL_W(1)) bb ();

  scan_decoder #(
    .SEL_W(2),
    .DWELL(4)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ba.slave)
  );

  scan_decoder #(
    .SEL_W(1),
    .DWELL(1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bb.slave)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: position = start + (enabled scan cycles)/DWELL, mod N
  int mn[2] = '{4, 2};
  int md[2] = '{4, 1};
  bit m_in[2];
  int m_t[2];
  int m_st[2];
  int e_idx[2];
  int e_y[2];
  int e_wrap[2];

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_in[k]   = 1'b0;
      m_t[k]    = 0;
      m_st[k]   = 0;
      e_idx[k]  = 0;
      e_y[k]    = 0;
      e_wrap[k] = 0;
    end
  endtask

  task automatic m_step(input int k, input bit en,
                        input bit mode, input int sel);
    e_wrap[k] = 0;
    if (!mode) begin
      m_in[k]  = 1'b0;
      e_idx[k] = sel;
      e_y[k]   = en ? (1 << sel) : 0;
    end else if (!m_in[k]) begin
      m_in[k]  = 1'b1;
      m_st[k]  = sel;
      m_t[k]   = 0;
      e_idx[k] = sel;
      e_y[k]   = en ? (1 << sel) : 0;
    end else if (en) begin
      m_t[k]++;
      e_idx[k] = (m_st[k] + m_t[k] / md[k]) % mn[k];
      e_wrap[k] = (m_t[k] % md[k] == 0) && (e_idx[k] == 0);
      e_y[k]   = 1 << e_idx[k];
    end else begin
      e_y[k] = 0;
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " a.y"}, 64'(ba.y), 64'(e_y[0]));
    chk({tag, " a.idx"}, 64'(ba.idx), 64'(e_idx[0]));
    chk({tag, " a.wrap"}, 64'(ba.wrap), 64'(e_wrap[0]));
    chk({tag, " b.y"}, 64'(bb.y), 64'(e_y[1]));
    chk({tag, " b.idx"}, 64'(bb.idx), 64'(e_idx[1]));
    chk({tag, " b.wrap"}, 64'(bb.wrap), 64'(e_wrap[1]));
  endtask

  // drive at negedge, step model at posedge, sample 1ns later
  task automatic cyc(input bit ea, input bit ma, input logic [1:0] sa,
                     input bit eb, input bit mb, input logic sb);
    @(negedge clk);
    ba.en   = ea;
    ba.mode = ma;
    ba.sel  = sa;
    bb.en   = eb;
    bb.mode = mb;
    bb.sel  = sb;
    @(posedge clk);
    m_step(0, ea, ma, int'(sa));
    m_step(1, eb, mb, int'(sb));
    #1;
    cmp_model("model");
  endtask

  always @(negedge clk) begin
    checks++;
    if (!$onehot0(ba.y) || $isunknown(ba.y) ||
        !$onehot0(bb.y) || $isunknown(bb.y)) begin
      fails++;
      $display("FAIL onehot: a.y=%b b.y=%b", ba.y, bb.y);
    end
  end

  typedef struct {
    bit         en;
    bit         mode;
    logic [1:0] sel;
    logic [3:0] y;
    logic [1:0] idx;
    bit         wrap;
  } vec_t;

  function automatic vec_t mk(bit en, bit mode, logic [1:0] sel,
                              logic [3:0] y, logic [1:0] idx, bit wrap);
    vec_t v;
    v.en   = en;
    v.mode = mode;
    v.sel  = sel;
    v.y    = y;
    v.idx  = idx;
    v.wrap = wrap;
    return v;
  endfunction

  vec_t tv[$];

  initial begin
    bit ea;
    bit ma;
    bit eb;
    bit mb;
    int bi;

    ba.en = 0; ba.mode = 0; ba.sel = '0;
    bb.en = 0; bb.mode = 0; bb.sel = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset a.y", 64'(ba.y), 64'd0);
    chk("reset a.idx", 64'(ba.idx), 64'd0);
    chk("reset a.wrap", 64'(ba.wrap), 64'd0);
    chk("reset b.y", 64'(bb.y), 64'd0);
    rst = 1'b0;
    m_reset();

    tv.push_back(mk(1, 0, 2, 4'b0100, 2, 0));
    tv.push_back(mk(0, 0, 3, 4'b0000, 3, 0));
    tv.push_back(mk(1, 0, 3, 4'b1000, 3, 0));
    tv.push_back(mk(1, 1, 1, 4'b0010, 1, 0));
    for (int i = 0; i < 3; i++) tv.push_back(mk(1, 1, 3, 4'b0010, 1, 0));
    for (int i = 0; i < 4; i++) tv.push_back(mk(1, 1, 0, 4'b0100, 2, 0));
    for (int i = 0; i < 4; i++) tv.push_back(mk(1, 1, 2, 4'b1000, 3, 0));
    tv.push_back(mk(1, 1, 1, 4'b0001, 0, 1));
    tv.push_back(mk(1, 1, 1, 4'b0001, 0, 0));

    // dut_b scans from 0 throughout: entry, then toggles every edge
    foreach (tv[r]) begin
      cyc(tv[r].en, tv[r].mode, tv[r].sel, 1'b1, 1'b1, 1'b0);
      chk($sformatf("vec%0d y", r), 64'(ba.y), 64'(tv[r].y));
      chk($sformatf("vec%0d idx", r), 64'(ba.idx), 64'(tv[r].idx));
      chk($sformatf("vec%0d wrap", r), 64'(ba.wrap), 64'(tv[r].wrap));
      bi = r % 2;
      chk($sformatf("sweep%0d idx", r), 64'(bb.idx), 64'(bi));
      chk($sformatf("sweep%0d y", r), 64'(bb.y), 64'(1 << bi));
      chk($sformatf("sweep%0d wrap", r), 64'(bb.wrap),
          64'((r > 0 && bi == 0) ? 1 : 0));
    end

    // pause mid-dwell at cnt=2, idx=2
    cyc(1, 0, 0, 1, 1, 0);
    chk("exit direct y", 64'(ba.y), 64'b0001);
    cyc(1, 1, 2, 1, 1, 0);
    cyc(1, 1, 0, 1, 1, 0);
    cyc(1, 1, 1, 1, 1, 0);
    chk("pre-pause idx", 64'(ba.idx), 64'd2);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 3, 0, 1, 0);
      chk("pause y", 64'(ba.y), 64'd0);
      chk("pause idx", 64'(ba.idx), 64'd2);
      chk("pause wrap", 64'(ba.wrap), 64'd0);
    end
    cyc(1, 1, 0, 1, 1, 0);
    chk("resume1 idx", 64'(ba.idx), 64'd2);
    chk("resume1 y", 64'(ba.y), 64'b0100);
    cyc(1, 1, 0, 1, 1, 0);
    chk("resume2 idx", 64'(ba.idx), 64'd3);
    chk("resume2 y", 64'(ba.y), 64'b1000);

    // async reset between edges, released with mode still high
    cyc(1, 1, 0, 1, 1, 0);
    @(negedge clk);
    ba.sel = 2'd3;
    bb.sel = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async a.y", 64'(ba.y), 64'd0);
    chk("async a.idx", 64'(ba.idx), 64'd0);
    chk("async a.wrap", 64'(ba.wrap), 64'd0);
    chk("async b.y", 64'(bb.y), 64'd0);
    chk("async b.idx", 64'(bb.idx), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(posedge clk);
    m_step(0, 1, 1, 3);
    m_step(1, 1, 1, 1);
    #1;
    chk("reentry a.idx", 64'(ba.idx), 64'd3);
    chk("reentry a.y", 64'(ba.y), 64'b1000);
    chk("reentry b.idx", 64'(bb.idx), 64'd1);
    cmp_model("reentry");

    ea = 1; ma = 1; eb = 1; mb = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 20) == 0) ma = ~ma;
      if ($urandom_range(0, 20) == 0) mb = ~mb;
      ea = ($urandom_range(0, 5) != 0);
      eb = ($urandom_range(0, 5) != 0);
      cyc(ea, ma, 2'($urandom), eb, mb, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
